registers_bank_ctrl: RTL

Access controller in front of the ID-stage register bank. It multiplexes the bank's ports between the pipeline (ID reads, WB writes) and the debug unit. On a debug request it stalls the pipeline and waits a fixed drain window. It then either streams every register out over a valid/ready interface or performs one debug write, and finally returns the bank to the pipeline.

---
 rtl/registers_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/registers_bank_ctrl.sv
// registers_bank_ctrl
//
// Access controller in front of the ID-stage register bank. In IDLE the bank ports follow the
// pipeline (ID reads, WB writes). A debug request stalls the pipeline and waits a fixed drain
// window. The controller then either streams every register out over a valid/ready interface or
// issues one debug write. After that it hands the bank back to the pipeline.
//
// Optional feature: define REGISTERS_BANK_CTRL_DBG_WRITE_EN to build the debug single-write path
// and the WRITE state. Without it, the i_dbg_wr_* inputs are ignored and o_dbg_wr_done is tied 0.
//
// Ports:
//   i_clk, i_reset                 clock; asynchronous active-low reset
//   i_id_* / i_wb_*                pipeline read and write requests
//   i_dbg_dump_req                 start a full-bank dump (sampled in IDLE only)
//   i_dbg_wr_req/_addr/_data       debug single write (sampled in IDLE only)
//   o_dbg_wr_done                  one-cycle pulse when the debug write is issued
//   o_dump_* / i_dump_ready        dump stream (data, index, valid, last) and its ready
//   o_pipeline_stall, o_busy       freeze request to the pipeline; controller not idle
//   o_rb_* / i_rb_bus_a            register bank ports and port-A read data
module registers_bank_ctrl #(
  parameter int unsigned REGISTERS_BANK_SIZE = 32,
  parameter int unsigned REGISTERS_SIZE      = 32,
  parameter int unsigned DRAIN_CYCLES        = 3,
  localparam int unsigned AW = $clog2(REGISTERS_BANK_SIZE),
  localparam int unsigned DW = REGISTERS_SIZE
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_id_read_enable,
  input  logic [AW-1:0] i_id_addr_a,
  input  logic [AW-1:0] i_id_addr_b,
  input  logic          i_wb_write_enable,
  input  logic [AW-1:0] i_wb_addr_wr,
  input  logic [DW-1:0] i_wb_bus_wr,
  input  logic          i_dbg_dump_req,
  input  logic          i_dbg_wr_req,
  input  logic [AW-1:0] i_dbg_wr_addr,
  input  logic [DW-1:0] i_dbg_wr_data,
  output logic          o_dbg_wr_done,
  output logic [DW-1:0] o_dump_data,
  output logic [AW-1:0] o_dump_addr,
  output logic          o_dump_valid,
  output logic          o_dump_last,
  input  logic          i_dump_ready,
  output logic          o_pipeline_stall,
  output logic          o_busy,
  output logic          o_rb_read_enable,
  output logic [AW-1:0] o_rb_addr_a,
  output logic [AW-1:0] o_rb_addr_b,
  output logic          o_rb_write_enable,
  output logic [AW-1:0] o_rb_addr_wr,
  output logic [DW-1:0] o_rb_bus_wr,
  input  logic [DW-1:0] i_rb_bus_a
);

  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] LastIdx = AW'(REGISTERS_BANK_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDrain = 3'd1,
    StRead  = 3'd2,
    StHold  = 3'd3,
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
    StWrite = 3'd4,
`endif
    StDone  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          stall_q, stall_d;
  logic          busy_q;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_start;

`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
  logic          mode_dump_q, mode_dump_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          wr_done_q;
  // A simultaneous dump request wins; the write is dropped.
  assign write_start = i_dbg_wr_req & ~i_dbg_dump_req;
`else
  logic unused_dbg_wr;
  assign unused_dbg_wr = ^{i_dbg_wr_req, i_dbg_wr_addr, i_dbg_wr_data};
  assign write_start   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
    mode_dump_d = mode_dump_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_dbg_dump_req || write_start) begin
          state_d = StDrain;
          stall_d = 1'b1;
          cnt_d   = CW'(DRAIN_CYCLES);
          idx_d   = '0;
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
          mode_dump_d = i_dbg_dump_req;
          wr_addr_d   = i_dbg_wr_addr;
          wr_data_d   = i_dbg_wr_data;
`endif
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
          state_d = mode_dump_q ? StRead : StWrite;
`else
          state_d = StRead;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRead: begin
        // Bank latched the read on the falling edge; capture it now.
        data_d  = i_rb_bus_a;
        addr_d  = idx_q;
        valid_d = 1'b1;
        last_d  = (idx_q == LastIdx);
        state_d = StHold;
      end
      StHold: begin
        if (i_dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end
      end
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
      StWrite: state_d = StDone;
`endif
      StDone: begin
        stall_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      busy_q  <= (state_d != StIdle);
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mode_dump_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      mode_dump_q <= mode_dump_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_done_q   <= (state_d == StWrite);
    end
  end
  assign o_dbg_wr_done = wr_done_q;
`else
  assign o_dbg_wr_done = 1'b0;
`endif

  assign o_dump_data      = data_q;
  assign o_dump_addr      = addr_q;
  assign o_dump_valid     = valid_q;
  assign o_dump_last      = last_q;
  assign o_pipeline_stall = stall_q;
  assign o_busy           = busy_q;

  // Bank port mux: pipeline in IDLE, WB-only during DRAIN, debug otherwise.
  always_comb begin
    o_rb_read_enable  = 1'b0;
    o_rb_addr_a       = idx_q;
    o_rb_addr_b       = idx_q;
    o_rb_write_enable = 1'b0;
    o_rb_addr_wr      = '0;
    o_rb_bus_wr       = '0;
    unique case (state_q)
      StIdle: begin
        o_rb_read_enable  = i_id_read_enable;
        o_rb_addr_a       = i_id_addr_a;
        o_rb_addr_b       = i_id_addr_b;
        o_rb_write_enable = i_wb_write_enable;
        o_rb_addr_wr      = i_wb_addr_wr;
        o_rb_bus_wr       = i_wb_bus_wr;
      end
      StDrain: begin
        o_rb_write_enable = i_wb_write_enable;
        o_rb_addr_wr      = i_wb_addr_wr;
        o_rb_bus_wr       = i_wb_bus_wr;
      end
      StRead: o_rb_read_enable = 1'b1;
`ifdef REGISTERS_BANK_CTRL_DBG_WRITE_EN
      StWrite: begin
        o_rb_write_enable = 1'b1;
        o_rb_addr_wr      = wr_addr_q;
        o_rb_bus_wr       = wr_data_q;
      end
`endif
      default: ;
    endcase
  end

endmodule
